// File: rtl/vending_machine_param_if.sv
// Coin, refund and change-handshake signals between the coin front end and the vending controller.
interface vending_machine_param_if #(
  parameter int CREDIT_W = 8
);
  logic                N;
  logic                D;
  logic                Q;
  logic                cancel;
  logic                chg_ready;
  logic                open;
  logic                chg_valid;
  logic                busy;
  logic                coin_rej;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output N, D, Q, cancel, chg_ready,
    input  open, chg_valid, busy, coin_rej, credit
  );

  modport slave (
    input  N, D, Q, cancel, chg_ready,
    output open, chg_valid, busy, coin_rej, credit
  );
endinterface

// File: rtl/vending_machine_param.sv
// Vending controller: collects coins, vends one item per cycle, returns change one nickel at a time.
// state   | meaning
// COLLECT | accepting coins; vend or refund decided from registered inputs
// CHANGE  | paying out credit in nickels over chg_valid/chg_ready; coins rejected
module vending_machine_param #(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 8
) (
  input logic                    clk,
  input logic                    rstn,
  vending_machine_param_if.slave bus
);

  if (PRICE < 5 || PRICE > 200 || (PRICE % 5) != 0) begin : g_bad_price
    $error("vending_machine_param: PRICE must be a multiple of 5 in 5..200");
  end

  // Worst-case sum is (PRICE-5) held in COLLECT plus 40 cents of simultaneous coins.
  if ((64'(1) << CREDIT_W) <= 64'(PRICE + 35)) begin : g_bad_width
    $error("vending_machine_param: CREDIT_W too narrow for PRICE+35");
  end

  typedef enum logic {COLLECT, CHANGE} state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] NICKEL  = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] DIME    = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] QUARTER = CREDIT_W'(25);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] coin_val, sum;
  logic                r_N, r_D, r_Q, r_cancel;
  logic                coin_rej_q;
  logic                open_c, chg_valid_c;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= COLLECT;
      credit_q   <= '0;
      r_N        <= 1'b0;
      r_D        <= 1'b0;
      r_Q        <= 1'b0;
      r_cancel   <= 1'b0;
      coin_rej_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      r_N        <= bus.N;
      r_D        <= bus.D;
      r_Q        <= bus.Q;
      r_cancel   <= bus.cancel;
      coin_rej_q <= (state_q == CHANGE) && (r_N || r_D || r_Q);
    end
  end

  assign coin_val = (r_N ? NICKEL : '0) + (r_D ? DIME : '0) + (r_Q ? QUARTER : '0);
  assign sum      = credit_q + coin_val;

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    open_c      = 1'b0;
    chg_valid_c = 1'b0;
    case (state_q)
      COLLECT: begin
        // Cancel takes priority over a vend that the same coins would have paid for.
        if (r_cancel) begin
          if (sum != '0) begin
            credit_d = sum;
            state_d  = CHANGE;
          end
        end else if (sum >= PRICE_C) begin
          open_c   = 1'b1;
          credit_d = sum - PRICE_C;
          if (sum != PRICE_C) state_d = CHANGE;
        end else begin
          credit_d = sum;
        end
      end
      CHANGE: begin
        chg_valid_c = 1'b1;
        if (bus.chg_ready) begin
          credit_d = credit_q - NICKEL;
          if (credit_q == NICKEL) state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign bus.open      = open_c;
  assign bus.chg_valid = chg_valid_c;
  assign bus.busy      = (state_q == CHANGE);
  assign bus.coin_rej  = coin_rej_q;
  assign bus.credit    = credit_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: vector table with expectation queue (PRICE=15) plus a PRICE=50 reset sequence.
module tb_vending_machine_param;

  logic clk;
  logic rstn1, rstn2;

  vending_machine_param_if #(.CREDIT_W(8)) vif1 ();
  vending_machine_param_if #(.CREDIT_W(8)) vif2 ();

  vending_machine_param #(.PRICE(15), .CREDIT_W(8)) dut1 (.clk(clk), .rstn(rstn1), .bus(vif1));
  vending_machine_param #(.PRICE(50), .CREDIT_W(8)) dut2 (.clk(clk), .rstn(rstn2), .bus(vif2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic n, d, q, cancel, ready;
    logic open, valid, busy, rej;
    int   credit;
  } vec_t;

  typedef struct {
    int   idx;
    logic open, valid, busy, rej;
    int   credit;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t v(input logic n, d, q, c, r, o, va, b, rj, input int cr);
    vec_t t;
    t.n = n; t.d = d; t.q = q; t.cancel = c; t.ready = r;
    t.open = o; t.valid = va; t.busy = b; t.rej = rj; t.credit = cr;
    return t;
  endfunction

  // Expectations are consumed mid-cycle, after the driver has pushed them just past the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (vif1.open !== e.open || vif1.chg_valid !== e.valid || vif1.busy !== e.busy ||
          vif1.coin_rej !== e.rej || int'(vif1.credit) != e.credit) begin
        errors++;
        $display("FAIL vec%0d: got open=%b valid=%b busy=%b rej=%b credit=%0d, want open=%b valid=%b busy=%b rej=%b credit=%0d",
                 e.idx, vif1.open, vif1.chg_valid, vif1.busy, vif1.coin_rej, int'(vif1.credit),
                 e.open, e.valid, e.busy, e.rej, e.credit);
      end
    end
  end

  task automatic drive1(input int idx, input vec_t t);
    exp_t x;
    @(posedge clk);
    #1;
    vif1.N = t.n; vif1.D = t.d; vif1.Q = t.q; vif1.cancel = t.cancel; vif1.chg_ready = t.ready;
    x.idx = idx; x.open = t.open; x.valid = t.valid; x.busy = t.busy; x.rej = t.rej; x.credit = t.credit;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic step2(input logic n, d, q, r, rst);
    @(posedge clk);
    #1;
    vif2.N = n; vif2.D = d; vif2.Q = q; vif2.cancel = 1'b0; vif2.chg_ready = r; rstn2 = rst;
    @(negedge clk);
  endtask

  initial begin
    rstn1 = 1'b0; rstn2 = 1'b0;
    vif1.N = 0; vif1.D = 0; vif1.Q = 0; vif1.cancel = 0; vif1.chg_ready = 0;
    vif2.N = 0; vif2.D = 0; vif2.Q = 0; vif2.cancel = 0; vif2.chg_ready = 0;

    //          n d q c r  open val busy rej credit
    // reset state
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 0));
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 0));
    // three nickels, vend on the third, no change
    tbl.push_back(v(1,0,0,0,0, 0,0,0,0, 0));
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 0));
    tbl.push_back(v(1,0,0,0,0, 0,0,0,0, 5));
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 5));
    tbl.push_back(v(1,0,0,0,0, 0,0,0,0,10));
    tbl.push_back(v(0,0,0,0,0, 1,0,0,0,10));
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 0));
    // two dimes, vend, one nickel of change
    tbl.push_back(v(0,1,0,0,0, 0,0,0,0, 0));
    tbl.push_back(v(0,1,0,0,0, 0,0,0,0, 0));
    tbl.push_back(v(0,0,0,0,0, 1,0,0,0,10));
    tbl.push_back(v(0,0,0,0,1, 0,1,1,0, 5));
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 0));
    // quarter with a stalled dispenser for three cycles
    tbl.push_back(v(0,0,1,0,0, 0,0,0,0, 0));
    tbl.push_back(v(0,0,0,0,0, 1,0,0,0, 0));
    tbl.push_back(v(0,0,0,0,0, 0,1,1,0,10));
    tbl.push_back(v(0,0,0,0,0, 0,1,1,0,10));
    tbl.push_back(v(0,0,0,0,0, 0,1,1,0,10));
    tbl.push_back(v(0,0,0,0,1, 0,1,1,0,10));
    tbl.push_back(v(0,0,0,0,1, 0,1,1,0, 5));
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 0));
    // dime then cancel; nickel and cancel during CHANGE are rejected/ignored
    tbl.push_back(v(0,1,0,0,0, 0,0,0,0, 0));
    tbl.push_back(v(0,0,0,1,0, 0,0,0,0, 0));
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0,10));
    tbl.push_back(v(1,0,0,1,0, 0,1,1,0,10));
    tbl.push_back(v(0,0,0,0,0, 0,1,1,0,10));
    tbl.push_back(v(0,0,0,0,1, 0,1,1,1,10));
    tbl.push_back(v(0,0,0,0,1, 0,1,1,0, 5));
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 0));
    // nickel + dime + cancel together: refund beats vend
    tbl.push_back(v(1,1,0,1,0, 0,0,0,0, 0));
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 0));
    tbl.push_back(v(0,0,0,0,1, 0,1,1,0,15));
    tbl.push_back(v(0,0,0,0,1, 0,1,1,0,10));
    tbl.push_back(v(0,0,0,0,1, 0,1,1,0, 5));
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 0));
    // quarter + dime together: vend with 20 cents of change
    tbl.push_back(v(0,1,1,0,0, 0,0,0,0, 0));
    tbl.push_back(v(0,0,0,0,0, 1,0,0,0, 0));
    tbl.push_back(v(0,0,0,0,1, 0,1,1,0,20));
    tbl.push_back(v(0,0,0,0,1, 0,1,1,0,15));
    tbl.push_back(v(0,0,0,0,1, 0,1,1,0,10));
    tbl.push_back(v(0,0,0,0,1, 0,1,1,0, 5));
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 0));
    // cancel with no credit, ready high in COLLECT: nothing happens
    tbl.push_back(v(0,0,0,1,0, 0,0,0,0, 0));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0, 0));
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 0));

    // A nickel presented during the reset cycle must be dropped.
    repeat (2) @(posedge clk);
    #1 vif1.N = 1'b1;
    @(posedge clk);
    #1 rstn1 = 1'b1; vif1.N = 1'b0;

    for (int i = 0; i < tbl.size(); i++) drive1(i, tbl[i]);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    chk("scoreboard_drain", exp_q.size(), 0);

    // PRICE=50 unit: 10 + 25 + 40 = 75 -> vend on the third coin cycle with 25 change,
    // then reset after two handshakes discards the rest.
    step2(0,1,0,0,1);
    chk("p50_c0_credit", int'(vif2.credit), 0);
    step2(0,0,1,0,1);
    chk("p50_c1_credit", int'(vif2.credit), 0);
    step2(1,1,1,0,1);
    chk("p50_c2_credit", int'(vif2.credit), 10);
    step2(0,0,0,0,1);
    chk("p50_vend_open", int'(vif2.open), 1);
    chk("p50_vend_credit", int'(vif2.credit), 35);
    step2(0,0,0,1,1);
    chk("p50_chg_valid", int'(vif2.chg_valid), 1);
    chk("p50_chg_busy", int'(vif2.busy), 1);
    chk("p50_chg_open", int'(vif2.open), 0);
    chk("p50_chg_credit0", int'(vif2.credit), 25);
    step2(0,0,0,1,1);
    chk("p50_chg_credit1", int'(vif2.credit), 20);
    step2(0,0,1,1,0);
    chk("p50_pre_rst_credit", int'(vif2.credit), 15);
    chk("p50_pre_rst_valid", int'(vif2.chg_valid), 1);
    step2(0,0,0,0,1);
    chk("p50_rst_credit", int'(vif2.credit), 0);
    chk("p50_rst_valid", int'(vif2.chg_valid), 0);
    chk("p50_rst_busy", int'(vif2.busy), 0);
    chk("p50_rst_rej", int'(vif2.coin_rej), 0);
    step2(0,0,0,0,1);
    chk("p50_post_rst_credit", int'(vif2.credit), 0);
    chk("p50_post_rst_valid", int'(vif2.chg_valid), 0);
    chk("p50_post_rst_open", int'(vif2.open), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
